// File: rtl/vp_mode_if.sv
// Mode-controller signal bundle: switch/sync/enable inputs and the applied-mode status outputs.
// Handshake: no valid/ready; master drives the raw inputs every cycle, slave owns the mode/status outputs.
interface vp_mode_if #(
    parameter int SW_W    = 3,
    parameter int FRAME_W = 16
);
    logic [SW_W-1:0]    sw_in;
    logic               v_sync_in;
    logic               de_in;
    logic [SW_W-1:0]    mode_out;
    logic               pending;
    logic               mode_changed;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        output sw_in, v_sync_in, de_in,
        input  mode_out, pending, mode_changed, frame_cnt
    );

    modport slave (
        input  sw_in, v_sync_in, de_in,
        output mode_out, pending, mode_changed, frame_cnt
    );
endinterface

// File: rtl/vp_mode_ctrl.sv
// Switch synchroniser/debouncer plus a frame-boundary-gated mode register for the video processor.
// Modes only change on a v_sync rise outside active video, so a frame is never split across modes.
module vp_mode_ctrl #(
    parameter int              SW_W       = 3,
    parameter int              DB_CYCLES  = 16,
    parameter int              DB_W       = 20,
    parameter int              FRAME_W    = 16,
    parameter logic [SW_W-1:0] RESET_MODE = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    vp_mode_if.slave bus,
    output logic     dbg_state_o
);
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [SW_W-1:0]    sync1_q, sync2_q;
    logic [SW_W-1:0]    cand_q, cand_d;
    logic [SW_W-1:0]    stable_q, stable_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               v_sync_q;
    logic [FRAME_W-1:0] frame_q, frame_d;
    state_t             state_q;
    logic [SW_W-1:0]    mode_q;
    logic               changed_q;

    logic vs_rise;
    logic apply;

    assign vs_rise = bus.v_sync_in & ~v_sync_q;
    assign apply   = vs_rise & ~bus.de_in;

    // A differing sample restarts the run; the counter parks at DB_LAST while the run continues.
    always_comb begin
        cand_d   = cand_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q != cand_q) begin
            cand_d   = sync2_q;
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = cand_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_comb begin
        frame_d = frame_q;
        if (vs_rise) frame_d = frame_q + FRAME_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= RESET_MODE;
            sync2_q  <= RESET_MODE;
            cand_q   <= RESET_MODE;
            stable_q <= RESET_MODE;
            db_cnt_q <= '0;
            v_sync_q <= 1'b0;
            frame_q  <= '0;
        end else begin
            sync1_q  <= bus.sw_in;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            v_sync_q <= bus.v_sync_in;
            frame_q  <= frame_d;
        end
    end

    // stable_q is the pre-edge value, so a debounce update on the apply edge is picked up next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= RESET_MODE;
            changed_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (stable_q != mode_q) state_q <= PENDING;
                end
                PENDING: begin
                    if (stable_q == mode_q) begin
                        state_q <= IDLE;
                    end else if (apply) begin
                        mode_q    <= stable_q;
                        changed_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mode_out     = mode_q;
    assign bus.pending      = (state_q == PENDING);
    assign bus.mode_changed = changed_q;
    assign bus.frame_cnt    = frame_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_vp_mode_ctrl.sv
// Directed bench for vp_mode_ctrl: debounce timing, frame-boundary gating, revert, wrap and async reset.
module tb_vp_mode_ctrl;
    localparam int SW_W    = 3;
    localparam int FRAME_W = 4;

    logic clk;
    logic rst_n;
    logic dbg_state;

    vp_mode_if #(.SW_W(SW_W), .FRAME_W(FRAME_W)) bus ();

    vp_mode_ctrl #(
        .SW_W(SW_W), .DB_CYCLES(16), .DB_W(20), .FRAME_W(FRAME_W), .RESET_MODE(3'b000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state_o(dbg_state)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [FRAME_W-1:0] exp_frame;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance n rising edges and land 1ns after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pending(input string tag);
        int k;
        k = 0;
        while (bus.pending !== 1'b1 && k < 40) begin
            cyc(1);
            k++;
        end
        chk(tag, {31'd0, bus.pending}, 32'd1);
    endtask

    // One v_sync pulse: high for hi cycles, then low for one; de held at de_v while high.
    task automatic vs_pulse(input logic de_v, input int hi);
        bus.v_sync_in = 1'b1;
        bus.de_in     = de_v;
        cyc(hi);
        bus.v_sync_in = 1'b0;
        bus.de_in     = 1'b0;
        cyc(1);
        exp_frame = exp_frame + 1'b1;
    endtask

    initial begin
        int pend_seen;
        int pulses;

        // Reset with arbitrary inputs, checked before the first clock edge.
        rst_n         = 1'b0;
        bus.sw_in     = 3'b101;
        bus.v_sync_in = 1'b1;
        bus.de_in     = 1'b1;
        exp_frame     = '0;
        #2;
        chk("rst_mode", {29'd0, bus.mode_out}, 32'd0);
        chk("rst_pending", {31'd0, bus.pending}, 32'd0);
        chk("rst_changed", {31'd0, bus.mode_changed}, 32'd0);
        chk("rst_frame", {28'd0, bus.frame_cnt}, 32'd0);
        bus.sw_in     = 3'b000;
        bus.v_sync_in = 1'b0;
        bus.de_in     = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);

        // Bounce: 5-cycle toggles never accumulate 16 identical samples.
        pend_seen = 0;
        for (int i = 0; i < 40; i++) begin
            bus.sw_in = (i % 2 == 0) ? 3'b001 : 3'b000;
            for (int j = 0; j < 5; j++) begin
                cyc(1);
                if (bus.pending === 1'b1) pend_seen++;
            end
        end
        bus.sw_in = 3'b000;
        for (int j = 0; j < 30; j++) begin
            cyc(1);
            if (bus.pending === 1'b1) pend_seen++;
        end
        chk("bounce_pend_cycles", 32'(pend_seen), 32'd0);
        chk("bounce_mode", {29'd0, bus.mode_out}, 32'd0);

        // Revert while pending: 000 -> 011 -> 000 with no v_sync.
        bus.sw_in = 3'b011;
        wait_pending("revert_pend_set");
        bus.sw_in = 3'b000;
        pulses = 0;
        for (int j = 0; j < 25; j++) begin
            cyc(1);
            if (bus.mode_changed === 1'b1) pulses++;
        end
        chk("revert_pend_clr", {31'd0, bus.pending}, 32'd0);
        chk("revert_pulses", 32'(pulses), 32'd0);
        chk("revert_mode", {29'd0, bus.mode_out}, 32'd0);

        // vs_rise in IDLE: counts a frame, no mode change.
        vs_pulse(1'b0, 1);
        chk("idle_vs_mode", {29'd0, bus.mode_out}, 32'd0);
        chk("idle_vs_frame", {28'd0, bus.frame_cnt}, {28'd0, exp_frame});

        // Clean change: first sample at e0, pending visible after e0+19.
        bus.sw_in = 3'b001;
        cyc(19);
        chk("clean_pend_e18", {31'd0, bus.pending}, 32'd0);
        cyc(1);
        chk("clean_pend_e19", {31'd0, bus.pending}, 32'd1);
        chk("clean_state_dbg", {31'd0, dbg_state}, 32'd1);
        bus.v_sync_in = 1'b1;
        bus.de_in     = 1'b0;
        cyc(1);
        chk("clean_mode", {29'd0, bus.mode_out}, 32'd1);
        chk("clean_pulse", {31'd0, bus.mode_changed}, 32'd1);
        // v_sync held high: one rise only.
        cyc(6);
        chk("clean_pulse_gone", {31'd0, bus.mode_changed}, 32'd0);
        chk("clean_pend_clr", {31'd0, bus.pending}, 32'd0);
        bus.v_sync_in = 1'b0;
        cyc(1);
        exp_frame = exp_frame + 1'b1;
        chk("clean_frame", {28'd0, bus.frame_cnt}, {28'd0, exp_frame});

        // Guarded boundary: rise during de is ignored for apply.
        bus.sw_in = 3'b010;
        wait_pending("guard_pend");
        vs_pulse(1'b1, 1);
        chk("guard_mode_hold", {29'd0, bus.mode_out}, 32'd1);
        chk("guard_pend_hold", {31'd0, bus.pending}, 32'd1);
        chk("guard_frame", {28'd0, bus.frame_cnt}, {28'd0, exp_frame});
        vs_pulse(1'b0, 1);
        chk("guard_mode_apply", {29'd0, bus.mode_out}, 32'd2);

        // Third value while pending: latest stable applied, one pulse.
        bus.sw_in = 3'b100;
        wait_pending("third_pend");
        bus.sw_in = 3'b101;
        cyc(25);
        chk("third_still_pend", {31'd0, bus.pending}, 32'd1);
        bus.v_sync_in = 1'b1;
        bus.de_in     = 1'b0;
        pulses = 0;
        for (int j = 0; j < 5; j++) begin
            cyc(1);
            if (j == 0) chk("third_mode", {29'd0, bus.mode_out}, 32'd5);
            if (bus.mode_changed === 1'b1) pulses++;
        end
        bus.v_sync_in = 1'b0;
        cyc(1);
        exp_frame = exp_frame + 1'b1;
        chk("third_pulses", 32'(pulses), 32'd1);

        // Stable changes on the apply edge: old value applied, new one pends next edge.
        bus.sw_in = 3'b111;
        wait_pending("same_pend");
        bus.sw_in = 3'b000;
        cyc(18);
        chk("same_pre_mode", {29'd0, bus.mode_out}, 32'd5);
        bus.v_sync_in = 1'b1;
        bus.de_in     = 1'b0;
        cyc(1);
        chk("same_mode", {29'd0, bus.mode_out}, 32'd7);
        chk("same_pend_drop", {31'd0, bus.pending}, 32'd0);
        cyc(1);
        chk("same_repend", {31'd0, bus.pending}, 32'd1);
        bus.v_sync_in = 1'b0;
        cyc(1);
        exp_frame = exp_frame + 1'b1;
        vs_pulse(1'b0, 1);
        chk("same_second_apply", {29'd0, bus.mode_out}, 32'd0);

        // Frame counter wrap.
        while (exp_frame != 4'd15) vs_pulse(1'b1, 1);
        chk("wrap_15", {28'd0, bus.frame_cnt}, 32'd15);
        vs_pulse(1'b1, 1);
        chk("wrap_0", {28'd0, bus.frame_cnt}, 32'd0);

        // Reset mid-pending, then re-debounce of the held switch.
        bus.sw_in = 3'b110;
        wait_pending("rstmid_pend");
        vs_pulse(1'b1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_mode", {29'd0, bus.mode_out}, 32'd0);
        chk("rstmid_pend", {31'd0, bus.pending}, 32'd0);
        chk("rstmid_frame", {28'd0, bus.frame_cnt}, 32'd0);
        cyc(2);
        rst_n     = 1'b1;
        exp_frame = '0;
        cyc(19);
        chk("redb_pend_e18", {31'd0, bus.pending}, 32'd0);
        cyc(1);
        chk("redb_pend_e19", {31'd0, bus.pending}, 32'd1);
        bus.v_sync_in = 1'b1;
        bus.de_in     = 1'b0;
        cyc(1);
        chk("redb_mode", {29'd0, bus.mode_out}, 32'd6);
        chk("redb_pulse", {31'd0, bus.mode_changed}, 32'd1);
        bus.v_sync_in = 1'b0;
        cyc(1);
        exp_frame = exp_frame + 1'b1;
        chk("redb_frame", {28'd0, bus.frame_cnt}, {28'd0, exp_frame});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
